// File: rtl/key_debounce_pkg.sv
// Shared helpers for the push-button debouncer: prescaler/counter sizing and raw pin levels.
package key_debounce_pkg;

  // Raw pin level of a released key, indexed by the active-low flag.
  localparam logic [1:0] KEY_RELEASED_RAW = 2'b10;

  function automatic int unsigned tick_cycles(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned debounce_ms);
    int unsigned w;
    w = $clog2(debounce_ms);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One debounced key: 2-flop synchroniser, stable-time counter, level flop and edge strobes.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_MS);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_MS - 1);
  localparam logic RelLevel = KEY_RELEASED_RAW[KEY_ACTIVE_LOW];

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            key_sync;

  // XOR with the released level yields logical pressed = 1 for either polarity.
  assign key_sync = sync_q[1] ^ RelLevel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= {2{RelLevel}};
      cnt_q       <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_raw};
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (key_sync == key_state) begin
        cnt_q <= '0;
      end else if (tick) begin
        if (cnt_q == CntLast) begin
          key_state   <= ~key_state;
          cnt_q       <= '0;
          key_press   <= ~key_state;
          key_release <= key_state;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS push-buttons against a shared 1 ms tick and drives the key PIO level.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 8,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned KEY_ACTIVE_LOW = 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int unsigned TickCycles = tick_cycles(CLK_HZ);
  localparam int unsigned PreW = cnt_width(TickCycles);
  localparam logic [PreW-1:0] PreLast = PreW'(TickCycles - 1);

  initial begin
    if ((CLK_HZ % 1000) != 0 || CLK_HZ < 2000) begin
      $fatal(1, "key_debounce: CLK_HZ must be a multiple of 1000 and at least 2000");
    end
    if (DEBOUNCE_MS < 1) begin
      $fatal(1, "key_debounce: DEBOUNCE_MS must be at least 1");
    end
  end

  logic [PreW-1:0] pre_q;
  logic            tick;

  assign tick = (pre_q == PreLast);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PreW'(1);
    end
  end

  for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_MS   (DEBOUNCE_MS),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW != 0)
    ) u_cell (
      .clk        (clk_clk),
      .rst        (reset_reset),
      .tick       (tick),
      .key_raw    (key_raw[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule
